// File: rtl/m_0_pkg.sv
// Shared defaults and label type for the taint-tracking data register.
package m_0_pkg;

    localparam int unsigned DATA_W_DEF  = 2;
    localparam int unsigned TAINT_W_DEF = 32;

    typedef logic [TAINT_W_DEF-1:0] taint_t;

endpackage

// File: rtl/m_0_taint_or.sv
// Conditional OR of taint labels: the data label only contributes when the
// select lets data through; control and clock labels always contribute.
module ift_taint_or #(
    parameter int unsigned TAINT_W = m_0_pkg::TAINT_W_DEF
) (
    input  logic               sel,
    input  logic [TAINT_W-1:0] data_t,
    input  logic [TAINT_W-1:0] ctrl_t,
    input  logic [TAINT_W-1:0] clk_t,
    output logic [TAINT_W-1:0] next_t_c
);

    always_comb begin
        next_t_c = ctrl_t | clk_t;
        if (sel) begin
            next_t_c = next_t_c | data_t;
        end
    end

endmodule

// File: rtl/m_0.sv
// Data register with synchronous reset and a cycle-aligned taint label register.
module m_0
    import m_0_pkg::*;
#(
    parameter int unsigned      DATA_W  = DATA_W_DEF,
    parameter int unsigned      TAINT_W = TAINT_W_DEF,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic               CLK,
    input  logic               SRST,
    input  logic [TAINT_W-1:0] CLK_t,
    input  logic [TAINT_W-1:0] SRST_t,
    input  logic [DATA_W-1:0]  D,
    input  logic [TAINT_W-1:0] D_t,
    output logic [DATA_W-1:0]  Q,
    output logic [TAINT_W-1:0] Q_t
);

    // Power-up contents: reset value for data, untainted label.
    logic [DATA_W-1:0]  q_r  = RST_VAL;
    logic [TAINT_W-1:0] qt_r = '0;
    logic [TAINT_W-1:0] next_t_c;

    ift_taint_or #(
        .TAINT_W (TAINT_W)
    ) u_taint_or (
        .sel      (~SRST),
        .data_t   (D_t),
        .ctrl_t   (SRST_t),
        .clk_t    (CLK_t),
        .next_t_c (next_t_c)
    );

    // Both registers see the same sampled SRST, keeping data and label aligned.
    always_ff @(posedge CLK) begin
        if (SRST) begin
            q_r <= RST_VAL;
        end else begin
            q_r <= D;
        end
        qt_r <= next_t_c;
    end

    assign Q   = q_r;
    assign Q_t = qt_r;

endmodule

// File: tb/tb_m_0.sv
// Scoreboard bench for m_0: driver queues expected Q/Q_t, monitor checks after each edge.
module tb_m_0;
    import m_0_pkg::*;

    typedef struct {
        logic [1:0] q;
        taint_t     qt;
        string      name;
    } exp_t;

    typedef struct {
        taint_t     clk_t;
        logic       srst;
        taint_t     srst_t;
        logic [1:0] d;
        taint_t     d_t;
        logic [1:0] eq;
        taint_t     eqt;
        string      name;
    } vec_t;

    logic       CLK = 1'b0;
    logic       SRST;
    taint_t     CLK_t;
    taint_t     SRST_t;
    logic [1:0] D;
    taint_t     D_t;
    logic [1:0] Q;
    taint_t     Q_t;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    m_0 dut (
        .CLK    (CLK),
        .SRST   (SRST),
        .CLK_t  (CLK_t),
        .SRST_t (SRST_t),
        .D      (D),
        .D_t    (D_t),
        .Q      (Q),
        .Q_t    (Q_t)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [1:0] q_exp, input taint_t qt_exp);
        checks++;
        if (Q !== q_exp || Q_t !== qt_exp) begin
            errors++;
            $display("FAIL %s: got Q=%b Q_t=%h, expected Q=%b Q_t=%h",
                     name, Q, Q_t, q_exp, qt_exp);
        end
    endtask

    // Monitor: after each rising edge, compare against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check(e.name, e.q, e.qt);
            end
        end
    end

    vec_t vecs[] = '{
        '{32'h0, 1'b1, 32'h0,        2'b11, 32'h000000FF, 2'b00, 32'h0,        "reset_first"},
        '{32'h0, 1'b0, 32'h0,        2'b01, 32'h00000001, 2'b01, 32'h00000001, "pass_d01"},
        '{32'h0, 1'b1, 32'h00000002, 2'b11, 32'h0000000F, 2'b00, 32'h00000002, "reset_srst_t"},
        '{32'h0, 1'b0, 32'h00000008, 2'b10, 32'h00000004, 2'b10, 32'h0000000C, "pass_or_srst_t"},
        '{32'h80000000, 1'b0, 32'h0, 2'b11, 32'h0,        2'b11, 32'h80000000, "clk_t_msb"},
        '{32'h0, 1'b0, 32'h0,        2'b11, 32'h0,        2'b11, 32'h0,        "seq_pass_11"},
        '{32'h0, 1'b1, 32'h0,        2'b11, 32'h0,        2'b00, 32'h0,        "seq_reset"},
        '{32'h00000001, 1'b1, 32'h00000010, 2'b10, 32'hFFFF0000, 2'b00, 32'h00000011, "reset_clk_srst_t"},
        '{32'h0, 1'b0, 32'h0,        2'b01, 32'hFFFFFFFF, 2'b01, 32'hFFFFFFFF, "pass_all_ones"},
        '{32'h0, 1'b1, 32'h0,        2'b10, 32'hFFFFFFFF, 2'b00, 32'h0,        "reset_blocks_d_t"},
        '{32'h00000100, 1'b0, 32'h00200000, 2'b10, 32'h00004000, 2'b10, 32'h00204100, "pass_three_way"}
    };

    // Driver
    initial begin
        exp_t e;
        int   wait_cycles;
        SRST = 1'b1; CLK_t = '0; SRST_t = '0; D = 2'b11; D_t = '0;
        #1;
        check("power_up", 2'b00, 32'h0);

        foreach (vecs[i]) begin
            @(negedge CLK);
            CLK_t  = vecs[i].clk_t;
            SRST   = vecs[i].srst;
            SRST_t = vecs[i].srst_t;
            D      = vecs[i].d;
            D_t    = vecs[i].d_t;
            #1;
            if (i > 0) begin
                check({vecs[i].name, "_hold"}, vecs[i-1].eq, vecs[i-1].eqt);
            end
            e.q = vecs[i].eq; e.qt = vecs[i].eqt; e.name = vecs[i].name;
            sb.push_back(e);
        end

        // D changes mid-cycle: Q must hold until the following edge.
        @(negedge CLK);
        CLK_t = '0; SRST = 1'b0; SRST_t = '0; D = 2'b01; D_t = '0;
        e.q = 2'b01; e.qt = '0; e.name = "mid_first";
        sb.push_back(e);
        @(posedge CLK);
        #3;
        D = 2'b10;
        e.q = 2'b10; e.qt = '0; e.name = "mid_second";
        sb.push_back(e);
        #1;
        check("mid_hold", 2'b01, 32'h0);

        wait_cycles = 0;
        while (sb.size() > 0 && wait_cycles < 20) begin
            @(negedge CLK);
            wait_cycles++;
        end
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
